day3_engine_dispatch: RTL and testbench
=======================================

Name: day3_engine_dispatch

Overview:
- Sequencer that shares a pool of NUM_ENGINES bank-solver engines (the per-line max-two-digit joltage datapath) among one AXI4-Stream line input.
- Dispatches each incoming line to a free engine in round-robin order and tracks lines in flight.
- Accumulates per-line results in an OUTPUTWIDTH sum. After the tlast line's result returns, emits the frame total on an AXI4-Stream master.

Parameters:
- NUM_ENGINES, 4, number of attached solver engines (2..16).
- INPUTWIDTH, 64, line data width (binary-encoded decimal digit string).
- RESWIDTH, 7, per-engine result width (max 99).
- OUTPUTWIDTH, 64, frame sum width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- s_axis_tdata  in  INPUTWIDTH  line value
- s_axis_tvalid  in  1  line valid
- s_axis_tlast  in  1  last line of frame
- s_axis_tready  out  1  line accepted
- eng_req_data  out  INPUTWIDTH  shared line bus to engines
- eng_req_valid  out  NUM_ENGINES  one-hot dispatch strobe
- eng_req_ready  in  NUM_ENGINES  engine idle and able to take a line
- eng_res_valid  in  NUM_ENGINES  one-cycle result pulse per engine
- eng_res_data  in  NUM_ENGINES*RESWIDTH  packed results, engine i at [i*RESWIDTH +: RESWIDTH]
- m_axis_tdata  out  OUTPUTWIDTH  frame total
- m_axis_tvalid  out  1  total valid
- m_axis_tlast  out  1  equals m_axis_tvalid
- m_axis_tready  in  1  downstream ready
- inflight  out  $clog2(NUM_ENGINES+1)  lines dispatched, result pending
- err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=S_ACCEPT, rr_ptr=0, sum=0, inflight=0, err=0.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - Reset mid-frame discards everything; engines share rst_n.
- States:
  - S_ACCEPT: dispatch lines.
  - S_DRAIN: tlast line dispatched, waiting for results.
  - S_OUTPUT: presenting the total.
- Grant (combinational): g = first index with eng_req_ready[g]=1, searching from rr_ptr upward with wrap.
- s_axis_tready = (state==S_ACCEPT) && |eng_req_ready.
- eng_req_valid[g] = s_axis_tvalid && s_axis_tready; all other bits 0.
- eng_req_data = s_axis_tdata (pass-through, zero latency).
- Dispatch fires when s_axis_tvalid && s_axis_tready:
  - rr_ptr <= (g+1) mod NUM_ENGINES.
  - If s_axis_tlast, state <= S_DRAIN.
- rr_ptr is unchanged when nothing is dispatched.
- Results are accepted every cycle in every state; there is no backpressure.
  - res_sum = sum of eng_res_data[i] over all i with eng_res_valid[i]; up to NUM_ENGINES results in one cycle.
  - sum <= sum + res_sum, modulo 2^OUTPUTWIDTH.
- inflight_next = inflight + dispatch − popcount(eng_res_valid). A simultaneous dispatch and return both count.
- err is set (sticky until reset) on any of:
  - popcount(eng_res_valid) > inflight + dispatch (underflow; inflight saturates at 0).
  - eng_res_valid in S_OUTPUT.
  - eng_req_ready[i] && eng_res_valid[i] in the same cycle.
- S_DRAIN -> S_OUTPUT when inflight_next==0.
  - m_axis_tvalid rises the cycle after the final result pulse.
  - m_axis_tdata equals the sum including that result.
- S_OUTPUT:
  - m_axis_tvalid=1; m_axis_tdata stable while stalled.
  - On m_axis_tvalid && m_axis_tready: m_axis_tvalid <= 0, sum <= 0, state <= S_ACCEPT.
  - s_axis_tready stays 0 throughout S_OUTPUT.
- Latency:
  - Line to engine: 0 cycles.
  - Last result to m_axis_tvalid: 1 cycle.
  - Minimum S_DRAIN occupancy: 1 cycle, since the tlast line is always in flight.
- Single-line frame (tvalid and tlast on the first beat) is legal and behaves as above.
- All engines busy: s_axis_tready=0 and the input stalls. The line is presented to an engine only when a grant exists.

Test Plan:
- Four lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 (last with tlast) into NUM_ENGINES=4 behavioural engines with latency 16 -> dispatched to engines 0,1,2,3 in order; results 98,89,78,92; m_axis_tdata=357 one cycle after the last result; m_axis_tlast=1.
- Same frame with NUM_ENGINES=2 and engine latencies 5/20 -> s_axis_tready drops while both are busy; inflight never exceeds 2; total 357; err=0.
- Round-robin fairness: rr_ptr=2 with engines 0 and 3 ready -> grant to 3, rr_ptr becomes 0; next grant to 0 when both stay ready.
- Four results pulsing in the same cycle as a new dispatch -> inflight changes by +1−4; the sum adds all four values; no lost result.
- m_axis_tready held low 10 cycles in S_OUTPUT -> tdata stable at 357, s_axis_tready=0; on handshake sum=0; the next frame of line 111 sums to 11.
- Spurious eng_res_valid with inflight=0 -> err=1 and stays set. Reset asserted in S_DRAIN -> tvalid=0, inflight=0, err=0, state S_ACCEPT immediately (asynchronous).

Source files
------------

// File: rtl/day3_engine_dispatch_if.sv
// day3_engine_dispatch_if: AXI4-Stream bundle with master and slave views
interface day3_engine_dispatch_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/day3_engine_dispatch.sv
// day3_engine_dispatch: round-robin line dispatch to solver engines with frame-sum accumulation
module day3_engine_dispatch #(
  parameter int NUM_ENGINES = 4,
  parameter int INPUTWIDTH  = 64,
  parameter int RESWIDTH    = 7,
  parameter int OUTPUTWIDTH = 64
)(
  input  logic                              clk,
  input  logic                              rst_n,
  day3_engine_dispatch_if.slave             s_axis,
  day3_engine_dispatch_if.master            m_axis,
  output logic [INPUTWIDTH-1:0]             eng_req_data,
  output logic [NUM_ENGINES-1:0]            eng_req_valid,
  input  logic [NUM_ENGINES-1:0]            eng_req_ready,
  input  logic [NUM_ENGINES-1:0]            eng_res_valid,
  input  logic [NUM_ENGINES*RESWIDTH-1:0]   eng_res_data,
  output logic [$clog2(NUM_ENGINES+1)-1:0]  inflight,
  output logic                              err
);
  localparam int IW = $clog2(NUM_ENGINES);
  localparam int CW = $clog2(NUM_ENGINES + 1);
  typedef enum logic [1:0] {S_ACCEPT, S_DRAIN, S_OUTPUT} state_t;
  state_t                 state, state_nx;
  logic [IW-1:0]          rr_ptr, gnt;
  logic [OUTPUTWIDTH-1:0] sum, sum_nx, res_sum, total;
  logic [CW:0]            res_cnt, avail;
  logic [CW-1:0]          inflight_nx;
  logic                   dispatch, under, err_nx, drain_done, out_done;
  int                     idx;
  // round-robin grant: the smallest offset from rr_ptr wins, so offsets are scanned high to low
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_ENGINES;
      if (eng_req_ready[idx]) gnt = IW'(idx);
    end
  end
  assign s_axis.tready = (state == S_ACCEPT) && |eng_req_ready;
  assign dispatch      = s_axis.tvalid && s_axis.tready;
  assign eng_req_valid = NUM_ENGINES'(dispatch) << gnt;
  assign eng_req_data  = s_axis.tdata;
  assign m_axis.tvalid = state == S_OUTPUT;
  assign m_axis.tlast  = m_axis.tvalid;
  assign m_axis.tdata  = total;
  // every returning result is absorbed in the cycle it pulses; several may land together
  always_comb begin
    res_sum = '0;
    res_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      res_sum = res_sum + (eng_res_valid[i] ? OUTPUTWIDTH'(eng_res_data[i*RESWIDTH +: RESWIDTH]) : '0);
      res_cnt = res_cnt + (CW+1)'(eng_res_valid[i]);
    end
  end
  assign avail       = {1'b0, inflight} + (CW+1)'(dispatch);
  assign under       = res_cnt > avail;
  assign inflight_nx = under ? '0 : CW'(avail - res_cnt);
  assign sum_nx      = sum + res_sum;
  assign err_nx      = under || (|eng_res_valid && state == S_OUTPUT) || |(eng_req_ready & eng_res_valid);
  assign drain_done  = state == S_DRAIN && inflight_nx == '0;
  assign out_done    = state == S_OUTPUT && m_axis.tready;
  // frame sequencing: accept until tlast, drain outstanding lines, then hold the total
  always_comb begin
    state_nx = state;
    if (state == S_ACCEPT && dispatch && s_axis.tlast) state_nx = S_DRAIN;
    else if (drain_done) state_nx = S_OUTPUT;
    else if (out_done) state_nx = S_ACCEPT;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_ACCEPT;
    else state <= state_nx;
  // pointer, accumulator, in-flight count and sticky error; total is latched so it cannot move while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr   <= '0;
      sum      <= '0;
      total    <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (dispatch) rr_ptr <= (gnt == IW'(NUM_ENGINES - 1)) ? '0 : gnt + 1'b1;
      sum      <= out_done ? '0 : sum_nx;
      if (drain_done) total <= sum_nx;
      inflight <= inflight_nx;
      err      <= err || err_nx;
    end
endmodule

// File: tb/tb_day3_engine_dispatch.sv
// tb_day3_engine_dispatch: directed checks of dispatch, accumulation, stall and error handling
module tb_day3_engine_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int pass_cnt = 0;
  int total_cnt = 0;
  day3_engine_dispatch_if #(.W(64)) sa(), ma(), sb(), mb();
  logic [63:0] a_req_data, b_req_data;
  logic [3:0]  a_req_valid, a_rdy, a_rv, a_man_rdy, a_man_rv, a_beh_rdy, a_beh_rv;
  logic [27:0] a_rd, a_man_rd, a_beh_rd;
  logic [1:0]  b_req_valid, b_rdy, b_rv;
  logic [13:0] b_rd;
  logic [2:0]  a_inflight;
  logic [1:0]  b_inflight;
  logic        a_err, b_err, auto;
  int          a_cnt[4];
  int          b_cnt[2];
  int          b_lat[2] = '{5, 20};
  logic [6:0]  a_res[4];
  logic [6:0]  b_res[2];
  int          b_max;
  logic        b_stalled;
  logic [63:0] lines[4] = '{64'd987654321111111, 64'd811111111111119, 64'd234234234234278, 64'd818181911112111};

  day3_engine_dispatch #(.NUM_ENGINES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis(sa), .m_axis(ma),
    .eng_req_data(a_req_data), .eng_req_valid(a_req_valid), .eng_req_ready(a_rdy),
    .eng_res_valid(a_rv), .eng_res_data(a_rd), .inflight(a_inflight), .err(a_err));
  day3_engine_dispatch #(.NUM_ENGINES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis(sb), .m_axis(mb),
    .eng_req_data(b_req_data), .eng_req_valid(b_req_valid), .eng_req_ready(b_rdy),
    .eng_res_valid(b_rv), .eng_res_data(b_rd), .inflight(b_inflight), .err(b_err));

  function automatic logic [6:0] joltage(input logic [63:0] v);
    int d[$];
    int best = 0;
    while (v != 0) begin
      d.push_front(int'(v % 10));
      v = v / 10;
    end
    for (int i = 0; i < d.size(); i++)
      for (int j = i + 1; j < d.size(); j++)
        if (10 * d[i] + d[j] > best) best = 10 * d[i] + d[j];
    return 7'(best);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) a_cnt[i] <= 0;
      a_beh_rv <= '0;
      a_beh_rd <= '0;
    end else
      for (int i = 0; i < 4; i++) begin
        a_beh_rv[i] <= 1'b0;
        if (a_cnt[i] != 0) begin
          a_cnt[i] <= a_cnt[i] - 1;
          if (a_cnt[i] == 1) begin
            a_beh_rv[i] <= 1'b1;
            a_beh_rd[i*7 +: 7] <= a_res[i];
          end
        end else if (a_req_valid[i] && auto) begin
          a_cnt[i] <= 16;
          a_res[i] <= joltage(a_req_data);
        end
      end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) b_cnt[i] <= 0;
      b_rv <= '0;
      b_rd <= '0;
    end else
      for (int i = 0; i < 2; i++) begin
        b_rv[i] <= 1'b0;
        if (b_cnt[i] != 0) begin
          b_cnt[i] <= b_cnt[i] - 1;
          if (b_cnt[i] == 1) begin
            b_rv[i] <= 1'b1;
            b_rd[i*7 +: 7] <= b_res[i];
          end
        end else if (b_req_valid[i]) begin
          b_cnt[i] <= b_lat[i];
          b_res[i] <= joltage(b_req_data);
        end
      end

  always_comb begin
    a_beh_rdy = '0;
    b_rdy = '0;
    for (int i = 0; i < 4; i++) a_beh_rdy[i] = a_cnt[i] == 0 && !a_beh_rv[i];
    for (int i = 0; i < 2; i++) b_rdy[i] = b_cnt[i] == 0 && !b_rv[i];
  end
  assign a_rdy = auto ? a_beh_rdy : a_man_rdy;
  assign a_rv  = auto ? a_beh_rv : a_man_rv;
  assign a_rd  = auto ? a_beh_rd : a_man_rd;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [63:0] d, input logic l, output logic [3:0] gv, output logic [63:0] gd);
    sa.tdata = d;
    sa.tlast = l;
    sa.tvalid = 1'b1;
    #1;
    for (int t = 0; t < 200 && sa.tready !== 1'b1; t++) cyc();
    gv = a_req_valid;
    gd = a_req_data;
    cyc();
    sa.tvalid = 1'b0;
    sa.tlast = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input logic l);
    sb.tdata = d;
    sb.tlast = l;
    sb.tvalid = 1'b1;
    #1;
    for (int t = 0; t < 200 && sb.tready !== 1'b1; t++) begin
      b_stalled = 1'b1;
      cyc();
      if (int'(b_inflight) > b_max) b_max = int'(b_inflight);
    end
    cyc();
    if (int'(b_inflight) > b_max) b_max = int'(b_inflight);
    sb.tvalid = 1'b0;
    sb.tlast = 1'b0;
  endtask

  task automatic test_reset();
    auto = 1'b1;
    sa.tvalid = 0; sa.tlast = 0; sa.tdata = '0;
    sb.tvalid = 0; sb.tlast = 0; sb.tdata = '0;
    ma.tready = 0; mb.tready = 1;
    a_man_rdy = '0; a_man_rv = '0; a_man_rd = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (ma.tvalid !== 1'b0 || ma.tdata !== 64'd0 || ma.tlast !== 1'b0)
      $display("FAIL reset_out: tvalid=%b tdata=%0d tlast=%b, want 0/0/0", ma.tvalid, ma.tdata, ma.tlast);
    else pass_cnt++;
    total_cnt++;
    if (a_inflight !== 3'd0 || a_err !== 1'b0)
      $display("FAIL reset_state: inflight=%0d err=%b, want 0/0", a_inflight, a_err);
    else pass_cnt++;
    total_cnt++;
    if (sa.tready !== 1'b1 || a_req_valid !== 4'b0000)
      $display("FAIL reset_ready: tready=%b req_valid=%b, want 1/0000", sa.tready, a_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (mb.tvalid !== 1'b0 || b_inflight !== 2'd0 || b_err !== 1'b0)
      $display("FAIL reset_b: tvalid=%b inflight=%0d err=%b, want 0/0/0", mb.tvalid, b_inflight, b_err);
    else pass_cnt++;
  endtask

  task automatic test_frame();
    logic [3:0] gv, prev;
    logic [63:0] gd;
    logic seen, bad;
    for (int k = 0; k < 4; k++) begin
      send_a(lines[k], k == 3, gv, gd);
      total_cnt++;
      if (gv !== (4'b0001 << k) || gd !== lines[k])
        $display("FAIL dispatch%0d: valid=%b data=%0d, want valid=%b data=%0d", k, gv, gd, 4'b0001 << k, lines[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (a_inflight !== 3'd4 || sa.tready !== 1'b0)
      $display("FAIL frame_inflight: inflight=%0d tready=%b, want 4/0", a_inflight, sa.tready);
    else pass_cnt++;
    prev = '0;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (ma.tvalid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      prev = a_rv;
      cyc();
    end
    total_cnt++;
    if (!seen || prev !== 4'b1000)
      $display("FAIL frame_latency: seen=%b prior res_valid=%b, want 1/1000", seen, prev);
    else pass_cnt++;
    total_cnt++;
    if (ma.tdata !== 64'd357 || ma.tlast !== 1'b1)
      $display("FAIL frame_total: tdata=%0d tlast=%b, want 357/1", ma.tdata, ma.tlast);
    else pass_cnt++;
    bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      cyc();
      if (ma.tvalid !== 1'b1 || ma.tdata !== 64'd357 || sa.tready !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad)
      $display("FAIL stall_hold: tvalid=%b tdata=%0d tready=%b, want 1/357/0 for 10 cycles", ma.tvalid, ma.tdata, sa.tready);
    else pass_cnt++;
    ma.tready = 1'b1;
    cyc();
    ma.tready = 1'b0;
    total_cnt++;
    if (ma.tvalid !== 1'b0 || sa.tready !== 1'b1)
      $display("FAIL stall_release: tvalid=%b tready=%b, want 0/1", ma.tvalid, sa.tready);
    else pass_cnt++;
    send_a(64'd111, 1'b1, gv, gd);
    total_cnt++;
    if (gv !== 4'b0001)
      $display("FAIL second_dispatch: valid=%b, want 0001", gv);
    else pass_cnt++;
    for (int t = 0; t < 100 && ma.tvalid !== 1'b1; t++) cyc();
    total_cnt++;
    if (ma.tvalid !== 1'b1 || ma.tdata !== 64'd11)
      $display("FAIL second_total: tvalid=%b tdata=%0d, want 1/11", ma.tvalid, ma.tdata);
    else pass_cnt++;
    ma.tready = 1'b1;
    cyc();
    ma.tready = 1'b0;
  endtask

  task automatic test_two_engines();
    b_max = 0;
    b_stalled = 1'b0;
    for (int k = 0; k < 4; k++) send_b(lines[k], k == 3);
    for (int t = 0; t < 200 && mb.tvalid !== 1'b1; t++) begin
      cyc();
      if (int'(b_inflight) > b_max) b_max = int'(b_inflight);
    end
    total_cnt++;
    if (b_stalled !== 1'b1 || b_max != 2)
      $display("FAIL two_eng_stall: stalled=%b max_inflight=%0d, want 1/2", b_stalled, b_max);
    else pass_cnt++;
    total_cnt++;
    if (mb.tvalid !== 1'b1 || mb.tdata !== 64'd357 || b_err !== 1'b0)
      $display("FAIL two_eng_total: tvalid=%b tdata=%0d err=%b, want 1/357/0", mb.tvalid, mb.tdata, b_err);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_rr_fairness();
    logic [3:0] gv;
    logic [63:0] gd;
    auto = 1'b0;
    a_man_rdy = 4'b1111;
    send_a(64'd100, 1'b0, gv, gd);
    total_cnt++;
    if (gv !== 4'b0010)
      $display("FAIL rr_start: valid=%b, want 0010", gv);
    else pass_cnt++;
    a_man_rdy = 4'b1001;
    send_a(64'd101, 1'b0, gv, gd);
    total_cnt++;
    if (gv !== 4'b1000)
      $display("FAIL rr_skip: valid=%b, want 1000", gv);
    else pass_cnt++;
    send_a(64'd102, 1'b0, gv, gd);
    total_cnt++;
    if (gv !== 4'b0001 || a_inflight !== 3'd3)
      $display("FAIL rr_wrap: valid=%b inflight=%0d, want 0001/3", gv, a_inflight);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] gv;
    logic [63:0] gd;
    a_man_rdy = 4'b0100;
    a_man_rv = 4'b1111;
    a_man_rd = {7'd40, 7'd30, 7'd20, 7'd10};
    send_a(64'd200, 1'b0, gv, gd);
    a_man_rv = 4'b0000;
    total_cnt++;
    if (gv !== 4'b0100 || a_inflight !== 3'd0 || a_err !== 1'b1)
      $display("FAIL simul_results: valid=%b inflight=%0d err=%b, want 0100/0/1", gv, a_inflight, a_err);
    else pass_cnt++;
    a_man_rdy = 4'b0001;
    send_a(64'd300, 1'b1, gv, gd);
    a_man_rdy = 4'b0000;
    total_cnt++;
    if (gv !== 4'b0001 || a_inflight !== 3'd1 || sa.tready !== 1'b0)
      $display("FAIL simul_last: valid=%b inflight=%0d tready=%b, want 0001/1/0", gv, a_inflight, sa.tready);
    else pass_cnt++;
    a_man_rv = 4'b0001;
    a_man_rd = {21'd0, 7'd7};
    cyc();
    a_man_rv = 4'b0000;
    total_cnt++;
    if (ma.tvalid !== 1'b1 || ma.tdata !== 64'd107 || a_inflight !== 3'd0)
      $display("FAIL simul_total: tvalid=%b tdata=%0d inflight=%0d, want 1/107/0", ma.tvalid, ma.tdata, a_inflight);
    else pass_cnt++;
    ma.tready = 1'b1;
    cyc();
    ma.tready = 1'b0;
  endtask

  task automatic test_err_reset();
    logic [3:0] gv;
    logic [63:0] gd;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (a_err !== 1'b0 || a_inflight !== 3'd0)
      $display("FAIL err_clear: err=%b inflight=%0d, want 0/0", a_err, a_inflight);
    else pass_cnt++;
    a_man_rdy = 4'b0000;
    a_man_rv = 4'b0010;
    a_man_rd = {21'd0, 7'd55};
    cyc();
    a_man_rv = 4'b0000;
    total_cnt++;
    if (a_err !== 1'b1 || a_inflight !== 3'd0)
      $display("FAIL spurious: err=%b inflight=%0d, want 1/0", a_err, a_inflight);
    else pass_cnt++;
    repeat (3) cyc();
    total_cnt++;
    if (a_err !== 1'b1)
      $display("FAIL err_sticky: err=%b, want 1", a_err);
    else pass_cnt++;
    a_man_rdy = 4'b0001;
    send_a(64'd5, 1'b1, gv, gd);
    total_cnt++;
    if (sa.tready !== 1'b0 || a_inflight !== 3'd1)
      $display("FAIL drain_entry: tready=%b inflight=%0d, want 0/1", sa.tready, a_inflight);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ma.tvalid !== 1'b0 || a_inflight !== 3'd0 || a_err !== 1'b0 || sa.tready !== 1'b1)
      $display("FAIL async_reset: tvalid=%b inflight=%0d err=%b tready=%b, want 0/0/0/1", ma.tvalid, a_inflight, a_err, sa.tready);
    else pass_cnt++;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_two_engines();
    test_rr_fairness();
    test_simultaneous();
    test_err_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
